// File: rtl/spram_be_clr.sv
// rtl/spram_be_clr.sv - single-port RAM with byte enables, registered read and clear engine
//
// Purpose:
//   DEPTH x DATA_W single-port synchronous RAM. Writes honour per-byte enables.
//   Reads are registered with a one-cycle rvalid strobe. A clear engine zeroes
//   one word per cycle after reset (INIT_ON_RESET = 1) or on a clr pulse. While
//   it runs, busy is high and all accesses are dropped.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - synchronous, active-high reset
//   me     - memory enable (access request this cycle)
//   wen    - 1 = write, 0 = read (qualified by me)
//   be     - byte write enables, be[i] covers wdata[8i+7:8i]
//   addr   - word address
//   wdata  - write data
//   clr    - single-cycle request to zero the whole array
//   rdata  - registered read data, holds between reads
//   rvalid - one-cycle strobe marking new rdata
//   busy   - clear engine active

module spram_be_clr #(
   parameter int DATA_W        = 64,
   parameter int ADDR_W        = 16,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                me,
   input  logic                wen,
   input  logic [DATA_W/8-1:0] be,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                clr,
   output logic [DATA_W-1:0]   rdata,
   output logic                rvalid,
   output logic                busy
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      READY = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam state_t RESET_STATE = INIT_ON_RESET ? CLEAR : READY;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   cnt, cnt_n;

   // Single shared write port: the clear engine and user writes both go
   // through these, so the array has exactly one write path.
   logic [NB-1:0]       wr_be;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                rd_en;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RESET_STATE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wr_be   = '0;
      wr_addr = addr;
      wr_data = wdata;
      rd_en   = 1'b0;

      case (state)
         CLEAR: begin
            wr_be   = '1;
            wr_addr = cnt;
            wr_data = '0;
            // cnt wraps to 0 naturally on the last word.
            cnt_n   = cnt + 1'b1;
            if (&cnt) begin
               state_n = READY;
            end
         end
         default: begin
            // clr outranks any access presented in the same cycle.
            if (clr) begin
               state_n = CLEAR;
               cnt_n   = '0;
            end else if (me && wen) begin
               wr_be = be;
            end else if (me) begin
               rd_en = 1'b1;
            end
         end
      endcase
   end

   // No reset loop over the array; writes are simply suppressed while reset
   // is held so contents survive it untouched.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) begin
            rdata <= mem[addr];
         end
      end
   end

   assign busy = (state == CLEAR);

endmodule

// File: doc/spram_be_clr.md
# spram_be_clr

Parametrised single-port synchronous RAM, the successor to the fixed 64x65536 single-port memory. It adds configurable width and depth, per-byte write enables and a registered read with a valid strobe. A hardware clear engine zeroes the array one word per cycle after reset or on request, with a busy flag. It sits behind datapath masters that need a deterministic-content scratch memory.

## Interface
- DATA_W, 64, word width in bits; must be a multiple of 8
- ADDR_W, 16, address width; DEPTH = 2**ADDR_W words
- INIT_ON_RESET, 1, 1 = run the clear engine automatically after reset; 0 = contents undefined until `clr`
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- me  input  1  memory enable; access request this cycle
- wen  input  1  1 = write, 0 = read (qualified by me)
- be  input  DATA_W/8  byte write enables; be[i] covers wdata[8i+7:8i]
- addr  input  ADDR_W  word address
- wdata  input  DATA_W  write data
- clr  input  1  single-cycle request to zero the whole array
- rdata  output  DATA_W  registered read data
- rvalid  output  1  high for one cycle when rdata carries a new read result
- busy  output  1  clear engine active; accesses are dropped

## Operation
- States: READY, CLEAR. Clear counter `cnt` is ADDR_W bits wide.
- Reset (sampled high): state = CLEAR if INIT_ON_RESET, else READY; cnt = 0; rdata = 0; rvalid = 0; busy = INIT_ON_RESET. Array contents are not touched while reset is held.
- CLEAR, each edge with reset low:
  - mem[cnt] = 0 and cnt = cnt + 1.
  - On the edge that writes address DEPTH-1: state = READY, busy = 0, cnt wraps to 0.
  - me, wen and clr are ignored. rvalid stays 0 and rdata holds its value.
- READY with clr = 1: state = CLEAR, busy = 1, cnt = 0. Any me access in the same cycle is dropped, because clr has priority.
- READY, me = 1, wen = 1: for each i with be[i] = 1, mem[addr] byte i = wdata byte i. Other bytes are unchanged. be = 0 is a no-op. rvalid = 0 and rdata holds.
- READY, me = 1, wen = 0: rdata = mem[addr] and rvalid = 1.
- READY, me = 0: rvalid = 0 and rdata holds its last value. The output is never driven to z.
- Reset mid-clear restarts the clear from address 0 (INIT_ON_RESET = 1) or abandons it (INIT_ON_RESET = 0).
- Storage is an inferred array of DEPTH x DATA_W with no out-of-range index. No reset loop runs over the array.

## Timing
- Read latency is 1. A read accepted at edge N gives rdata and rvalid = 1 after edge N. rvalid drops after edge N+1 unless another read is accepted there.
- Back-to-back reads are accepted every cycle, so sustained throughput is one access per clock.
- Read after write to the same address on the next cycle returns the new data. A single port makes same-cycle read and write impossible.
- Auto-clear duration is exactly DEPTH cycles. busy is high from reset release through the edge that writes DEPTH-1. The first access is accepted at the first edge where busy = 0.
- A clr pulse sampled at edge N raises busy after edge N. busy falls after edge N+DEPTH.
- A clr pulse while busy = 1 is ignored; it is neither queued nor restarted.

## Test plan
Use ADDR_W = 4 and DATA_W = 32 unless a scenario says otherwise.
- Reset held 3 cycles, then released, with INIT_ON_RESET = 1: busy stays high for exactly 16 cycles and rvalid = 0 throughout. After busy falls, reading all addresses 0-15 returns 0x00000000 with rvalid = 1 on each.
- Write addr 5 = 0xA1B2C3D4 with be = 4'hF, then write addr 5 = 0x11223344 with be = 4'b0101, then read addr 5: rdata = 0xA122C344 one cycle after the read request.
- Reads of addr 1, 2, 3 on consecutive cycles: rvalid is high for 3 consecutive cycles with the matching data. me = 0 the next cycle: rvalid = 0 and rdata holds addr 3's value.
- Write addr 7 = 0xDEADBEEF, then assert clr together with a write of addr 8 = 0x55. busy is high for 16 cycles, and accesses during busy produce no rvalid. Afterwards both addr 7 and addr 8 read 0.
- Reset asserted at clear cycle 6 of 16, held 1 cycle, then released: the clear restarts and busy stays high for a further 16 cycles. All words read 0 afterwards.
- INIT_ON_RESET = 0, reset released: busy = 0 immediately, and a write then read of addr 15 = 0x0F0F0F0F returns 0x0F0F0F0F with latency 1.
